// File: rtl/qformat_mac.sv
// Streaming signed Q-format multiply-accumulate.
// Emits one rescaled, rounded and saturated dot product per in_last-delimited vector.
module qformat_mac #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned FRAC_W = DATA_W - 1,
    parameter int unsigned ACC_W  = 2 * DATA_W + 4,
    parameter int unsigned ROUND  = 1,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [LEN_W-1:0]  out_len,
    output logic              out_sat
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SUM_W  = ACC_W + 1;

    localparam logic signed [SUM_W-1:0] ACC_MAX = $signed({2'b00, {(ACC_W-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] ACC_MIN = $signed({2'b11, {(ACC_W-1){1'b0}}});
    localparam logic signed [SUM_W-1:0] OUT_MAX =
        $signed({{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] OUT_MIN =
        $signed({{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});
    localparam logic signed [SUM_W-1:0] RND =
        (ROUND != 0 && FRAC_W > 0) ? ((SUM_W'(1) << FRAC_W) >> 1) : '0;

    logic                     en;
    logic                     accept;
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    logic signed [PROD_W-1:0] prod_c;

    logic                     v1;
    logic                     last1;
    logic signed [PROD_W-1:0] p1;

    logic signed [ACC_W-1:0]  acc;
    logic [LEN_W-1:0]         cnt;
    logic                     first;
    logic                     sticky;

    logic signed [SUM_W-1:0]  acc_base;
    logic signed [SUM_W-1:0]  sum_wide;
    logic signed [ACC_W-1:0]  sum_c;
    logic                     acc_clip;
    logic signed [SUM_W-1:0]  rnd_sum;
    logic signed [SUM_W-1:0]  shifted;
    logic [DATA_W-1:0]        res_c;
    logic                     narrow_clip;
    logic [LEN_W-1:0]         cnt_c;

    // Every stage advances together; a held result freezes the whole pipe.
    assign en       = !out_valid || out_ready;
    assign in_ready = rst_n && en;
    assign accept   = in_valid && in_ready;

    assign a_ext  = $signed({{DATA_W{in_a[DATA_W-1]}}, in_a});
    assign b_ext  = $signed({{DATA_W{in_b[DATA_W-1]}}, in_b});
    assign prod_c = a_ext * b_ext;

    // Stage 1: product register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            p1    <= '0;
        end else if (en) begin
            v1 <= accept;
            if (accept) begin
                p1    <= prod_c;
                last1 <= in_last;
            end
        end
    end

    // Stage 2 datapath: clamped accumulate, rescale, narrow
    always_comb begin
        acc_base    = first ? '0 : $signed({acc[ACC_W-1], acc});
        sum_wide    = acc_base + $signed({{(SUM_W-PROD_W){p1[PROD_W-1]}}, p1});
        acc_clip    = 1'b0;
        sum_c       = sum_wide[ACC_W-1:0];
        if (sum_wide > ACC_MAX) begin
            sum_c    = ACC_MAX[ACC_W-1:0];
            acc_clip = 1'b1;
        end else if (sum_wide < ACC_MIN) begin
            sum_c    = ACC_MIN[ACC_W-1:0];
            acc_clip = 1'b1;
        end

        rnd_sum     = $signed({sum_c[ACC_W-1], sum_c}) + RND;
        shifted     = rnd_sum >>> FRAC_W;
        narrow_clip = 1'b0;
        res_c       = shifted[DATA_W-1:0];
        if (shifted > OUT_MAX) begin
            res_c       = OUT_MAX[DATA_W-1:0];
            narrow_clip = 1'b1;
        end else if (shifted < OUT_MIN) begin
            res_c       = OUT_MIN[DATA_W-1:0];
            narrow_clip = 1'b1;
        end

        cnt_c = first ? LEN_W'(1) : ((&cnt) ? cnt : cnt + LEN_W'(1));
    end

    // Stage 2 state and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            first     <= 1'b1;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_len   <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            out_valid <= v1 && last1;
            if (v1) begin
                acc    <= sum_c;
                cnt    <= cnt_c;
                first  <= last1;
                sticky <= last1 ? 1'b0 : (sticky || acc_clip);
                if (last1) begin
                    out_data <= res_c;
                    out_len  <= cnt_c;
                    out_sat  <= sticky || acc_clip || narrow_clip;
                end
            end
        end
    end

endmodule
